// File: rtl/weapon_pkg.sv
// Shared weapon encodings: FSM states, sprite frame indices, one-hot weapon_state codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Port summary: none; imported by weapon_anim_sequencer and rendering_controller.
package weapon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOOT1 = 2'd1,
        ST_SHOOT2 = 2'd2,
        ST_RELOAD = 2'd3
    } wstate_t;

    // Sprite frame indices driven on frame_sel; reload sprites are FRAME_RELOAD0 + sub-frame.
    localparam logic [2:0] FRAME_IDLE    = 3'd0;
    localparam logic [2:0] FRAME_SHOOT1  = 3'd1;
    localparam logic [2:0] FRAME_SHOOT2  = 3'd2;
    localparam logic [2:0] FRAME_RELOAD0 = 3'd3;

    // One-hot weapon_state codes, also decoded by rendering_controller.
    localparam logic [2:0] WS_IDLE   = 3'b001;
    localparam logic [2:0] WS_SHOOT  = 3'b010;
    localparam logic [2:0] WS_RELOAD = 3'b100;

    function automatic logic [2:0] ws_decode(input wstate_t s);
        case (s)
            ST_SHOOT1, ST_SHOOT2: return WS_SHOOT;
            ST_RELOAD:            return WS_RELOAD;
            default:              return WS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/vblank_tick.sv
// Produces a one-cycle tick on the first cycle vCount equals VBLANK_LINE.
// Latency: combinational from vCount against a registered previous value.
// Backpressure: none; tick is a free-running pulse once per display frame.
// Ports: clk, reset (async active-low), vCount (current scan line), tick (start-of-vblank pulse).
module vblank_tick #(
    parameter int VBLANK_LINE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vCount,
    output logic       tick
);

    localparam logic [9:0] VB_LINE = 10'(VBLANK_LINE);

    logic [9:0] prev_vcount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_vcount <= '0;
        else        prev_vcount <= vCount;
    end

    // Rising match only: a line that sits at VBLANK_LINE for several clocks ticks once.
    assign tick = (vCount == VB_LINE) && (prev_vcount != VB_LINE);

endmodule

// File: rtl/weapon_anim_sequencer.sv
// Shotgun sprite sequencer (idle/shoot/reload) with ammo ownership; updates only at start of vblank.
// Latency: a request captured in IDLE shows on outputs at the next vblank tick edge (<= 1 frame).
// Backpressure: none; requests outside IDLE are dropped, fire_ack is a one-cycle pulse.
// Ports: clk, reset (async active-low), vCount, game_active, fire_req, reload_req in;
//        frame_sel, weapon_state (one-hot), ammo, fire_ack, busy out.
module weapon_anim_sequencer
    import weapon_pkg::*;
#(
    parameter int SHOOT_FRAMES  = 6,
    parameter int RELOAD_FRAMES = 8,
    parameter int AMMO_MAX      = 8,
    parameter int AUTO_RELOAD   = 1,
    parameter int VBLANK_LINE   = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vCount,
    input  logic       game_active,
    input  logic       fire_req,
    input  logic       reload_req,
    output logic [2:0] frame_sel,
    output logic [2:0] weapon_state,
    output logic [3:0] ammo,
    output logic       fire_ack,
    output logic       busy
);

    localparam logic [3:0] SHOOT_LAST  = 4'(SHOOT_FRAMES - 1);
    localparam logic [3:0] RELOAD_LAST = 4'(RELOAD_FRAMES - 1);
    localparam logic [3:0] AMMO_FULL   = 4'(AMMO_MAX);

    logic tick;

    vblank_tick #(.VBLANK_LINE(VBLANK_LINE)) u_vblank_tick (
        .clk    (clk),
        .reset  (reset),
        .vCount (vCount),
        .tick   (tick)
    );

    wstate_t    state, state_nxt;
    logic [3:0] tick_cnt, tick_cnt_nxt;
    logic [1:0] sub, sub_nxt;
    logic [3:0] ammo_nxt;
    logic [2:0] frame_sel_nxt;
    logic       fire_ack_nxt;
    logic       fire_pend, fire_pend_nxt;
    logic       reload_pend, reload_pend_nxt;
    logic       fire_now, reload_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            sub         <= '0;
            ammo        <= AMMO_FULL;
            frame_sel   <= FRAME_IDLE;
            fire_ack    <= 1'b0;
            fire_pend   <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            sub         <= sub_nxt;
            ammo        <= ammo_nxt;
            frame_sel   <= frame_sel_nxt;
            fire_ack    <= fire_ack_nxt;
            fire_pend   <= fire_pend_nxt;
            reload_pend <= reload_pend_nxt;
        end
    end

    // A request landing on the tick cycle itself is honoured rather than lost.
    assign fire_now   = fire_pend | fire_req;
    assign reload_now = reload_pend | reload_req;

    always_comb begin
        state_nxt       = state;
        tick_cnt_nxt    = tick_cnt;
        sub_nxt         = sub;
        ammo_nxt        = ammo;
        frame_sel_nxt   = frame_sel;
        fire_ack_nxt    = 1'b0;
        fire_pend_nxt   = fire_pend;
        reload_pend_nxt = reload_pend;

        if (state == ST_IDLE && !tick) begin
            if (fire_req)   fire_pend_nxt   = 1'b1;
            if (reload_req) reload_pend_nxt = 1'b1;
        end

        if (tick) begin
            if (state != ST_IDLE && !game_active) begin
                // Abort: shot keeps its spent shell, reload leaves ammo as it was.
                state_nxt       = ST_IDLE;
                tick_cnt_nxt    = '0;
                sub_nxt         = '0;
                frame_sel_nxt   = FRAME_IDLE;
                fire_pend_nxt   = 1'b0;
                reload_pend_nxt = 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        fire_pend_nxt   = 1'b0;
                        reload_pend_nxt = 1'b0;
                        tick_cnt_nxt    = '0;
                        sub_nxt         = '0;
                        if (game_active) begin
                            if (fire_now && ammo != 4'd0) begin
                                state_nxt     = ST_SHOOT1;
                                ammo_nxt      = ammo - 4'd1;
                                fire_ack_nxt  = 1'b1;
                                frame_sel_nxt = FRAME_SHOOT1;
                            end else if ((fire_now && ammo == 4'd0 && AUTO_RELOAD != 0) ||
                                         (reload_now && ammo < AMMO_FULL)) begin
                                state_nxt     = ST_RELOAD;
                                frame_sel_nxt = FRAME_RELOAD0;
                            end
                        end
                    end
                    ST_SHOOT1, ST_SHOOT2: begin
                        if (tick_cnt == SHOOT_LAST) begin
                            tick_cnt_nxt = '0;
                            if (state == ST_SHOOT1) begin
                                state_nxt     = ST_SHOOT2;
                                frame_sel_nxt = FRAME_SHOOT2;
                            end else begin
                                state_nxt     = ST_IDLE;
                                frame_sel_nxt = FRAME_IDLE;
                            end
                        end else begin
                            tick_cnt_nxt = tick_cnt + 4'd1;
                        end
                    end
                    ST_RELOAD: begin
                        if (tick_cnt == RELOAD_LAST) begin
                            tick_cnt_nxt = '0;
                            if (sub == 2'd3) begin
                                state_nxt     = ST_IDLE;
                                sub_nxt       = '0;
                                ammo_nxt      = AMMO_FULL;
                                frame_sel_nxt = FRAME_IDLE;
                            end else begin
                                sub_nxt       = sub + 2'd1;
                                frame_sel_nxt = FRAME_RELOAD0 + {1'b0, sub_nxt};
                            end
                        end else begin
                            tick_cnt_nxt = tick_cnt + 4'd1;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    assign weapon_state = ws_decode(state);
    assign busy         = (state != ST_IDLE);

endmodule
